// File: rtl/ubhcs_pipe_8_0_if.sv
// Operand/result handshake bundle for the ubhcs_pipe_8_0 subtractor.
// master drives operands and out_ready; slave is the subtractor side.
interface ubhcs_pipe_8_0_if #(
   parameter int W = 9
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] X;
   logic [W-1:0] Y;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] D;
   logic         BO;
   logic         OVF;

   modport master (
      output in_valid, X, Y, out_ready,
      input  in_ready, out_valid, D, BO, OVF
   );

   modport slave (
      input  in_valid, X, Y, out_ready,
      output in_ready, out_valid, D, BO, OVF
   );
endinterface

// File: rtl/ubhcs_pipe_8_0.sv
// Two-stage Han-Carlson unsigned subtractor, D = X + ~Y + 1.
// Define UBHCS_OVF_EN to add the registered signed-overflow flag.
module ubhcs_pipe_8_0 #(
   parameter int W = 9
) (
   input logic             clk,
   input logic             rst,
   ubhcs_pipe_8_0_if.slave bus
);
   localparam int CL = $clog2(W);

   logic         v1;
   logic         v2;
   logic         adv1;
   logic         adv2;
   logic [W-1:0] ga;
   logic [W-1:0] pa;
   logic [W-1:0] pz;
   logic [W-1:0] g1;
   logic [W-1:0] p1;
   logic [W-1:0] pz1;
   logic [W-1:0] gb;
   logic [W-1:0] pb;
   logic [W-1:0] gf;
   logic [W-1:0] c;
   logic [W-1:0] dn;
   logic         unused_p0;

   assign adv2         = !v2 || bus.out_ready;
   assign adv1         = v1 && adv2;
   assign bus.in_ready = (!v1 || adv2) && !rst;
   assign bus.out_valid = v2;

   // Carry-in of 1 is folded into bit 0's generate term.
   always_comb begin
      pz    = bus.X ^ ~bus.Y;
      ga    = bus.X & ~bus.Y;
      ga[0] = ga[0] | pz[0];
      pa    = pz;
      for (int k = 0; k < 2; k++) begin
         for (int i = W - 1; i > 0; i--) begin
            if (i % 2 == 1 && i >= (1 << k)) begin
               ga[i] = ga[i] | (pa[i] & ga[i - (1 << k)]);
               pa[i] = pa[i] & pa[i - (1 << k)];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1  <= 1'b0;
         g1  <= '0;
         p1  <= '0;
         pz1 <= '0;
      end else if (bus.in_ready) begin
         v1 <= bus.in_valid;
         if (bus.in_valid) begin
            g1  <= ga;
            p1  <= pa;
            pz1 <= pz;
         end
      end
   end

   always_comb begin
      gb = g1;
      pb = p1;
      for (int k = 2; k < CL; k++) begin
         for (int i = W - 1; i > 0; i--) begin
            if (i % 2 == 1 && i >= (1 << k)) begin
               gb[i] = gb[i] | (pb[i] & gb[i - (1 << k)]);
               pb[i] = pb[i] & pb[i - (1 << k)];
            end
         end
      end
      gf = gb;
      for (int i = 2; i < W; i += 2) begin
         gf[i] = gb[i] | (pb[i] & gb[i - 1]);
      end
      c  = {gf[W-2:0], 1'b1};
      dn = pz1 ^ c;
   end

   assign unused_p0 = pb[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         v2     <= 1'b0;
         bus.D  <= '0;
         bus.BO <= 1'b0;
      end else if (adv2) begin
         v2 <= v1;
         if (adv1) begin
            bus.D  <= dn;
            bus.BO <= ~gf[W-1];
         end
      end
   end

`ifdef UBHCS_OVF_EN
   logic xm1;
   logic ym1;

   always_ff @(posedge clk) begin
      if (rst) begin
         xm1 <= 1'b0;
         ym1 <= 1'b0;
      end else if (bus.in_ready && bus.in_valid) begin
         xm1 <= bus.X[W-1];
         ym1 <= bus.Y[W-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.OVF <= 1'b0;
      end else if (adv1) begin
         bus.OVF <= (xm1 ^ ym1) & (xm1 ^ dn[W-1]);
      end
   end
`else
   assign bus.OVF = 1'b0;
`endif
endmodule

// File: tb/tb_ubhcs_pipe_8_0.sv
// Directed checks for ubhcs_pipe_8_0 (W=9): reset, wrap/borrow,
// overflow, backpressure, streaming throughput and mid-flight reset.
module tb_ubhcs_pipe_8_0;
`ifdef UBHCS_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   vec  = 0;
   int   errs = 0;
   logic [8:0] xs [50];
   logic [8:0] ys [50];

   ubhcs_pipe_8_0_if #(.W(9)) bus ();

   ubhcs_pipe_8_0 #(.W(9)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic out_is(input string tag, input logic [8:0] d,
                         input logic bo, input logic ovf);
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".D"}, 32'(bus.D), 32'(d));
      chk({tag, ".BO"}, 32'(bus.BO), 32'(bo));
      chk({tag, ".OVF"}, 32'(bus.OVF), 32'(ovf));
   endtask

   task automatic send(input string tag, input logic [8:0] x,
                       input logic [8:0] y);
      bus.in_valid = 1'b1;
      bus.X        = x;
      bus.Y        = y;
      chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
   endtask

   function automatic logic ovf_m(input logic [8:0] x, input logic [8:0] y);
      int sx, sy, r;
      sx = x[8] ? int'(x) - 512 : int'(x);
      sy = y[8] ? int'(y) - 512 : int'(y);
      r  = sx - sy;
      return OVF_ON && (r < -256 || r > 255);
   endfunction

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.X         = '0;
      bus.Y         = '0;
      bus.out_ready = 1'b1;
      step();
      step();
      chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst.D", 32'(bus.D), 32'd0);
      chk("rst.BO", 32'(bus.BO), 32'd0);
      chk("rst.OVF", 32'(bus.OVF), 32'd0);
      rst = 1'b0;
      #1;
      chk("idle.in_ready", 32'(bus.in_ready), 32'd1);

      // 300 is negative as 9-bit signed, so signed overflow is real here
      send("basic", 9'd300, 9'd45);
      chk("basic.lat1", 32'(bus.out_valid), 32'd0);
      step();
      out_is("basic", 9'd255, 1'b0, OVF_ON);

      send("wrap", 9'd0, 9'd1);
      step();
      out_is("wrap", 9'd511, 1'b1, 1'b0);

      send("equal", 9'h155, 9'h155);
      step();
      out_is("equal", 9'd0, 1'b0, 1'b0);

      send("ovf", 9'd255, 9'h1FF);
      step();
      out_is("ovf", 9'h100, 1'b1, OVF_ON);
      step();
      chk("drain.valid", 32'(bus.out_valid), 32'd0);

      bus.out_ready = 1'b0;
      send("bp0", 9'd10, 9'd3);
      send("bp1", 9'd20, 9'd5);
      bus.in_valid = 1'b1;
      bus.X        = 9'd7;
      bus.Y        = 9'd9;
      chk("bp.full", 32'(bus.in_ready), 32'd0);
      chk("bp.hold0", 32'(bus.D), 32'd7);
      step();
      chk("bp.full1", 32'(bus.in_ready), 32'd0);
      chk("bp.hold1", 32'(bus.D), 32'd7);
      step();
      chk("bp.hold2", 32'(bus.D), 32'd7);
      bus.out_ready = 1'b1;
      #1;
      out_is("bp.r0", 9'd7, 1'b0, 1'b0);
      chk("bp.resume", 32'(bus.in_ready), 32'd1);
      step();
      out_is("bp.r1", 9'd15, 1'b0, 1'b0);
      bus.X = 9'd511;
      bus.Y = 9'd0;
      chk("bp.acc3", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      out_is("bp.r2", 9'd510, 1'b1, 1'b0);
      step();
      out_is("bp.r3", 9'd511, 1'b0, 1'b0);
      step();
      chk("bp.empty", 32'(bus.out_valid), 32'd0);

      for (int i = 0; i < 50; i++) begin
         xs[i] = 9'($urandom_range(0, 511));
         ys[i] = 9'($urandom_range(0, 511));
      end
      xs[0] = 9'd1;
      ys[0] = 9'd2;
      for (int t = 0; t < 52; t++) begin
         if (t < 50) begin
            bus.in_valid = 1'b1;
            bus.X        = xs[t];
            bus.Y        = ys[t];
            chk("tp.in_ready", 32'(bus.in_ready), 32'd1);
         end else begin
            bus.in_valid = 1'b0;
         end
         if (t >= 2) begin
            out_is("tp", xs[t-2] - ys[t-2], xs[t-2] < ys[t-2],
                   ovf_m(xs[t-2], ys[t-2]));
         end
         step();
      end
      chk("tp.empty", 32'(bus.out_valid), 32'd0);

      bus.out_ready = 1'b0;
      send("mr0", 9'd100, 9'd1);
      send("mr1", 9'd50, 9'd2);
      chk("mr.full", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mr.in_ready", 32'(bus.in_ready), 32'd0);
      step();
      chk("mr.valid", 32'(bus.out_valid), 32'd0);
      chk("mr.D", 32'(bus.D), 32'd0);
      chk("mr.BO", 32'(bus.BO), 32'd0);
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      send("mr.fresh", 9'd8, 9'd3);
      chk("mr.lat1", 32'(bus.out_valid), 32'd0);
      step();
      out_is("mr.res", 9'd5, 1'b0, 1'b0);
      step();
      chk("mr.empty", 32'(bus.out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
